// File: rtl/stream_unlock_pkg.sv
// rtl/stream_unlock_pkg.sv - shared types and key helper for the stream unlock gate
package stream_unlock_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    LOCKED   = 1'b0,
    UNLOCKED = 1'b1
  } gate_state_e;

  // Widest key the helper can address; keys are right-aligned in this width.
  localparam int unsigned KEY_MAX_BYTES = 32;

  // Byte i of a key_bytes-long key, byte 0 being the first one expected on the wire.
  function automatic byte_t key_byte(input logic [KEY_MAX_BYTES*8-1:0] key,
                                     input int unsigned key_bytes,
                                     input int unsigned i);
    return byte_t'(key >> ((key_bytes - 1 - i) * 8));
  endfunction

endpackage

// File: rtl/stream_unlock_gate_if.sv
// rtl/stream_unlock_gate_if.sv - receive, command, banner, response and transmit streams of the gate
interface stream_unlock_gate_if;
  import stream_unlock_pkg::*;

  logic  s_rx_tvalid;
  logic  s_rx_tready;
  byte_t s_rx_tdata;

  logic  m_cmd_tvalid;
  logic  m_cmd_tready;
  byte_t m_cmd_tdata;

  logic  s_banner_tvalid;
  logic  s_banner_tready;
  byte_t s_banner_tdata;

  logic  s_resp_tvalid;
  logic  s_resp_tready;
  byte_t s_resp_tdata;

  logic  m_tx_tvalid;
  logic  m_tx_tready;
  byte_t m_tx_tdata;

  // The gate itself.
  modport master (
    input  s_rx_tvalid, s_rx_tdata, output s_rx_tready,
    output m_cmd_tvalid, m_cmd_tdata, input m_cmd_tready,
    input  s_banner_tvalid, s_banner_tdata, output s_banner_tready,
    input  s_resp_tvalid, s_resp_tdata, output s_resp_tready,
    output m_tx_tvalid, m_tx_tdata, input m_tx_tready
  );

  // The surrounding FIFO, Wishbone master, sources and transmitter.
  modport slave (
    output s_rx_tvalid, s_rx_tdata, input s_rx_tready,
    input  m_cmd_tvalid, m_cmd_tdata, output m_cmd_tready,
    output s_banner_tvalid, s_banner_tdata, input s_banner_tready,
    output s_resp_tvalid, s_resp_tdata, input s_resp_tready,
    input  m_tx_tvalid, m_tx_tdata, output m_tx_tready
  );

endinterface

// File: rtl/stream_unlock_gate_key_matcher.sv
// rtl/stream_unlock_gate_key_matcher.sv - stream_key_matcher: tracks progress through the magic key
module stream_key_matcher
  import stream_unlock_pkg::*;
#(
  parameter int unsigned              KEY_BYTES = 15,
  parameter logic [KEY_BYTES*8-1:0]   KEY       = "#!manilamagic!#",
  localparam int unsigned             PW        = $clog2(KEY_BYTES + 1)
) (
  input  logic          clk,
  input  logic          sresetn,
  input  byte_t         in_byte,
  input  logic          in_valid,
  input  logic          clear,
  output logic [PW-1:0] progress,
  output logic          match
);

  localparam logic [KEY_MAX_BYTES*8-1:0] KEY_EXT = (KEY_MAX_BYTES*8)'(KEY);

  logic [PW-1:0] idx_q;
  logic [PW-1:0] idx_step;
  byte_t         expect_byte;
  byte_t         first_byte;

  // Next index for the incoming byte: advance, restart on the first key byte, or fall back to 0.
  // idx_q never reaches KEY_BYTES because a full match resets it.
  always_comb begin
    expect_byte = key_byte(KEY_EXT, KEY_BYTES, 32'(idx_q));
    first_byte  = key_byte(KEY_EXT, KEY_BYTES, 0);
    idx_step    = '0;
    if (in_byte == expect_byte) begin
      idx_step = idx_q + PW'(1);
    end else if (in_byte == first_byte) begin
      idx_step = PW'(1);
    end
  end

  assign match    = in_valid && !clear && (idx_step == PW'(KEY_BYTES));
  assign progress = idx_q;

  // Index register: cleared while unlocked and after a complete match.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      idx_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (in_valid) begin
      idx_q <= match ? '0 : idx_step;
    end
  end

endmodule

// File: rtl/stream_unlock_gate.sv
// rtl/stream_unlock_gate.sv - magic-key gate for bootloader rx/cmd and tx muxing; UNLOCK_TIMEOUT_EN adds idle relock
module stream_unlock_gate
  import stream_unlock_pkg::*;
#(
  parameter int unsigned            KEY_BYTES      = 15,
  parameter logic [KEY_BYTES*8-1:0] KEY            = "#!manilamagic!#",
  parameter int unsigned            TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                             clk,
  input  logic                             sresetn,
  stream_unlock_gate_if.master             bus,
  input  logic                             cmd_enable,
  input  logic                             lock_req,
  output logic                             unlocked,
  output logic                             unlock_pulse,
  output logic [$clog2(KEY_BYTES+1)-1:0]   key_progress
);

  gate_state_e state_q;
  gate_state_e state_d;
  logic        key_match;
  logic        timeout_hit;

  stream_key_matcher #(
    .KEY_BYTES (KEY_BYTES),
    .KEY       (KEY)
  ) u_matcher (
    .clk      (clk),
    .sresetn  (sresetn),
    .in_byte  (bus.s_rx_tdata),
    .in_valid ((state_q == LOCKED) && bus.s_rx_tvalid),
    .clear    (state_q == UNLOCKED),
    .progress (key_progress),
    .match    (key_match)
  );

`ifdef UNLOCK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q;
  logic          rx_hs;
  logic          tx_hs;

  assign rx_hs = bus.s_rx_tvalid && bus.s_rx_tready;
  assign tx_hs = bus.m_tx_tvalid && bus.m_tx_tready;

  assign timeout_hit = (state_q == UNLOCKED) && !rx_hs && !tx_hs &&
                       (idle_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while unlocked, restarts on any rx or tx handshake.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      idle_q <= '0;
    end else if ((state_q == LOCKED) || rx_hs || tx_hs || timeout_hit) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TW'(1);
    end
  end
`else
  // Always 0 for any legal TIMEOUT_CYCLES (>= 1): without the counter only lock_req relocks.
  assign timeout_hit = (TIMEOUT_CYCLES == 0);
`endif

  // State register plus the one-cycle pulse on entry to UNLOCKED.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q      <= LOCKED;
      unlock_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      unlock_pulse <= (state_q == LOCKED) && (state_d == UNLOCKED);
    end
  end

  // Next state: unlock on a full key, relock on request or idle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOCKED:   if (key_match) state_d = UNLOCKED;
      UNLOCKED: if (lock_req || timeout_hit) state_d = LOCKED;
      default:  state_d = LOCKED;
    endcase
  end

  // Stream routing: swallow rx and show the banner while locked, pass rx/resp through while unlocked.
  always_comb begin
    bus.s_rx_tready     = 1'b1;
    bus.m_cmd_tvalid    = 1'b0;
    bus.m_cmd_tdata     = bus.s_rx_tdata;
    bus.m_tx_tvalid     = bus.s_banner_tvalid;
    bus.m_tx_tdata      = bus.s_banner_tdata;
    bus.s_banner_tready = bus.m_tx_tready;
    bus.s_resp_tready   = 1'b1;
    if (state_q == UNLOCKED) begin
      bus.s_rx_tready     = cmd_enable && bus.m_cmd_tready;
      bus.m_cmd_tvalid    = cmd_enable && bus.s_rx_tvalid;
      bus.m_tx_tvalid     = cmd_enable && bus.s_resp_tvalid;
      bus.m_tx_tdata      = bus.s_resp_tdata;
      bus.s_banner_tready = 1'b0;
      bus.s_resp_tready   = cmd_enable ? bus.m_tx_tready : 1'b1;
    end
  end

  assign unlocked = (state_q == UNLOCKED);

endmodule

// File: tb/tb_stream_unlock_gate.sv
// tb/tb_stream_unlock_gate.sv - self-checking bench for stream_unlock_gate
module tb_stream_unlock_gate;
  import stream_unlock_pkg::*;

  localparam int KB = 15;
  localparam int TO = 16;
  localparam int PW = $clog2(KB + 1);

  logic          clk = 1'b0;
  logic          sresetn;
  logic          cmd_enable;
  logic          lock_req;
  logic          unlocked;
  logic          unlock_pulse;
  logic [PW-1:0] key_progress;

  always #5 clk = ~clk;

  stream_unlock_gate_if bus();

  stream_unlock_gate #(
    .KEY_BYTES      (KB),
    .KEY            ("#!manilamagic!#"),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .sresetn      (sresetn),
    .bus          (bus),
    .cmd_enable   (cmd_enable),
    .lock_req     (lock_req),
    .unlocked     (unlocked),
    .unlock_pulse (unlock_pulse),
    .key_progress (key_progress)
  );

  string key_s = "#!manilamagic!#";
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference state: lock flag, pulse, matched-byte count, idle cycles.
  bit    m_unl;
  bit    m_pulse;
  int    m_idx;
  int    m_idle;
  int    m_unlock_count;

  byte_t cmd_seen[$];
  byte_t tx_seen[$];

  typedef struct packed {
    logic [159:0] text;
    logic [7:0]   len;
    logic         exp_unlocked;
    logic [7:0]   exp_progress;
  } vec_t;

  vec_t vecs [0:10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic byte_t vec_char(input logic [159:0] t, input int len, input int i);
    return byte_t'(t >> ((len - 1 - i) * 8));
  endfunction

  task automatic idle_inputs();
    bus.s_rx_tvalid     = 1'b0;
    bus.s_rx_tdata      = 8'h00;
    bus.m_cmd_tready    = 1'b0;
    bus.s_banner_tvalid = 1'b0;
    bus.s_banner_tdata  = 8'h00;
    bus.s_resp_tvalid   = 1'b0;
    bus.s_resp_tdata    = 8'h00;
    bus.m_tx_tready     = 1'b0;
    cmd_enable          = 1'b0;
    lock_req            = 1'b0;
  endtask

  task automatic model_reset();
    m_unl   = 1'b0;
    m_pulse = 1'b0;
    m_idx   = 0;
    m_idle  = 0;
  endtask

  task automatic do_reset();
    sresetn = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    sresetn = 1'b1;
  endtask

  // One clock: check all outputs against the reference for the inputs now driven, then advance it.
  task automatic tick();
    bit    e_rx_rdy, e_cmd_v, e_tx_v, e_ban_rdy, e_resp_rdy;
    byte_t e_tx_d;
    bit    rx_hs, tx_hs, n_unl, n_pulse;
    int    n_idx, n_idle;
    byte_t b;
    #1;
    if (!m_unl) begin
      e_rx_rdy   = 1'b1;
      e_cmd_v    = 1'b0;
      e_tx_v     = bus.s_banner_tvalid;
      e_tx_d     = bus.s_banner_tdata;
      e_ban_rdy  = bus.m_tx_tready;
      e_resp_rdy = 1'b1;
    end else begin
      e_rx_rdy   = cmd_enable && bus.m_cmd_tready;
      e_cmd_v    = cmd_enable && bus.s_rx_tvalid;
      e_tx_v     = cmd_enable && bus.s_resp_tvalid;
      e_tx_d     = bus.s_resp_tdata;
      e_ban_rdy  = 1'b0;
      e_resp_rdy = cmd_enable ? bus.m_tx_tready : 1'b1;
    end
    chk("unlocked", unlocked, m_unl);
    chk("unlock_pulse", unlock_pulse, m_pulse);
    chk("key_progress", key_progress, m_idx);
    chk("s_rx_tready", bus.s_rx_tready, e_rx_rdy);
    chk("m_cmd_tvalid", bus.m_cmd_tvalid, e_cmd_v);
    chk("m_tx_tvalid", bus.m_tx_tvalid, e_tx_v);
    chk("s_banner_tready", bus.s_banner_tready, e_ban_rdy);
    chk("s_resp_tready", bus.s_resp_tready, e_resp_rdy);
    if (e_cmd_v) chk("m_cmd_tdata", bus.m_cmd_tdata, bus.s_rx_tdata);
    if (e_tx_v) chk("m_tx_tdata", bus.m_tx_tdata, e_tx_d);
    if (bus.m_cmd_tvalid && bus.m_cmd_tready) cmd_seen.push_back(bus.m_cmd_tdata);
    if (bus.m_tx_tvalid && bus.m_tx_tready) tx_seen.push_back(bus.m_tx_tdata);

    rx_hs   = bus.s_rx_tvalid && e_rx_rdy;
    tx_hs   = e_tx_v && bus.m_tx_tready;
    n_unl   = m_unl;
    n_pulse = 1'b0;
    n_idx   = m_idx;
    n_idle  = 0;
    if (!m_unl) begin
      if (rx_hs) begin
        b = bus.s_rx_tdata;
        if (b == byte_t'(key_s[m_idx]))   n_idx = m_idx + 1;
        else if (b == byte_t'(key_s[0]))  n_idx = 1;
        else                              n_idx = 0;
        if (n_idx == KB) begin
          n_unl   = 1'b1;
          n_pulse = 1'b1;
          n_idx   = 0;
          m_unlock_count++;
        end
      end
    end else if (lock_req) begin
      n_unl = 1'b0;
    end else begin
`ifdef UNLOCK_TIMEOUT_EN
      if (rx_hs || tx_hs)        n_idle = 0;
      else if (m_idle == TO - 1) n_unl  = 1'b0;
      else                       n_idle = m_idle + 1;
`endif
    end
    @(posedge clk); #1;
    m_unl   = n_unl;
    m_pulse = n_pulse;
    m_idx   = n_idx;
    m_idle  = n_idle;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.s_rx_tvalid = 1'b1;
      bus.s_rx_tdata  = byte_t'(s[i]);
      tick();
    end
    bus.s_rx_tvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int budget;
    string banner;
    m_unlock_count = 0;
    banner = "Manila";

    vecs[0]  = '{"#!manilamagic!#",     8'd15, 1'b1, 8'd0};
    vecs[1]  = '{"##!manilamagic!#",    8'd16, 1'b1, 8'd0};
    vecs[2]  = '{"#!manilamagiX",       8'd13, 1'b0, 8'd0};
    vecs[3]  = '{"#!mani",              8'd6,  1'b0, 8'd6};
    vecs[4]  = '{"#!manilamagic!",      8'd14, 1'b0, 8'd14};
    vecs[5]  = '{"x#!manilamagic!#",    8'd16, 1'b1, 8'd0};
    vecs[6]  = '{"#!ma#!manilamagic!#", 8'd19, 1'b1, 8'd0};
    vecs[7]  = '{"#!manilamagic!!",     8'd15, 1'b0, 8'd0};
    vecs[8]  = '{"!#!m",                8'd4,  1'b0, 8'd3};
    vecs[9]  = '{"#!#",                 8'd3,  1'b0, 8'd1};
    vecs[10] = '{"#!manilamagiX!#",     8'd15, 1'b0, 8'd1};

    // Reset state with a banner byte pending.
    do_reset();
    bus.s_banner_tvalid = 1'b1;
    bus.s_banner_tdata  = "Z";
    bus.m_tx_tready     = 1'b1;
    #1;
    chk("rst_unlocked", unlocked, 0);
    chk("rst_pulse", unlock_pulse, 0);
    chk("rst_progress", key_progress, 0);
    chk("rst_cmd_tvalid", bus.m_cmd_tvalid, 0);
    chk("rst_rx_tready", bus.s_rx_tready, 1);
    chk("rst_tx_tvalid", bus.m_tx_tvalid, 1);
    chk("rst_tx_tdata", bus.m_tx_tdata, "Z");
    tick();

    // Table of key sequences applied from reset.
    for (int v = 0; v < 11; v++) begin
      do_reset();
      cmd_seen.delete();
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        bus.s_rx_tvalid = 1'b1;
        bus.s_rx_tdata  = vec_char(vecs[v].text, int'(vecs[v].len), i);
        tick();
      end
      bus.s_rx_tvalid = 1'b0;
      chk($sformatf("vec%0d_unlocked", v), unlocked, vecs[v].exp_unlocked);
      chk($sformatf("vec%0d_progress", v), key_progress, vecs[v].exp_progress);
      chk($sformatf("vec%0d_pulse", v), unlock_pulse, vecs[v].exp_unlocked);
      chk($sformatf("vec%0d_no_cmd", v), cmd_seen.size(), 0);
    end

    // Unlock latency and first pass-through beat in the cycle after the final key byte.
    do_reset();
    cmd_seen.delete();
    send_str("#!manilamagic!#");
    chk("lat_unlocked", unlocked, 1);
    chk("lat_pulse", unlock_pulse, 1);
    cmd_enable       = 1'b1;
    bus.m_cmd_tready = 1'b1;
    bus.s_rx_tvalid  = 1'b1;
    bus.s_rx_tdata   = 8'h3C;
    #1;
    chk("first_cmd_tvalid", bus.m_cmd_tvalid, 1);
    chk("first_cmd_tdata", bus.m_cmd_tdata, 8'h3C);
    tick();
    bus.s_rx_tvalid = 1'b0;
    chk("pulse_one_cycle", unlock_pulse, 0);
    chk("first_cmd_count", cmd_seen.size(), 1);

    // cmd_enable=0 stalls the beat; then back-pressure on m_cmd is honoured.
    cmd_seen.delete();
    cmd_enable       = 1'b0;
    bus.m_cmd_tready = 1'b1;
    bus.s_rx_tvalid  = 1'b1;
    bus.s_rx_tdata   = 8'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rx_tready", bus.s_rx_tready, 0);
      tick();
    end
    cmd_enable       = 1'b1;
    bus.m_cmd_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_cmd_tvalid", bus.m_cmd_tvalid, 1);
      chk("bp_rx_tready", bus.s_rx_tready, 0);
      tick();
    end
    bus.m_cmd_tready = 1'b1;
    tick();
    bus.s_rx_tvalid  = 1'b0;
    chk("stall_cmd_count", cmd_seen.size(), 1);
    if (cmd_seen.size() == 1) chk("stall_cmd_data", cmd_seen[0], 8'h55);

    // Banner passes while locked, responses drain silently; after unlock resp reaches tx.
    do_reset();
    tx_seen.delete();
    bus.s_resp_tvalid = 1'b1;
    bus.s_resp_tdata  = 8'h77;
    sent   = 0;
    budget = 0;
    while (sent < banner.len() && budget < 100) begin
      bus.s_banner_tvalid = 1'b1;
      bus.s_banner_tdata  = byte_t'(banner[sent]);
      bus.m_tx_tready     = 1'($urandom_range(0, 1));
      if (bus.m_tx_tready) sent++;
      tick();
      budget++;
    end
    bus.s_banner_tvalid = 1'b0;
    chk("banner_count", tx_seen.size(), banner.len());
    for (int i = 0; i < tx_seen.size() && i < banner.len(); i++)
      chk($sformatf("banner_byte%0d", i), tx_seen[i], byte_t'(banner[i]));
    send_str("#!manilamagic!#");
    cmd_enable          = 1'b1;
    bus.s_banner_tvalid = 1'b1;
    bus.s_resp_tdata    = 8'hA5;
    bus.m_tx_tready     = 1'b1;
    #1;
    chk("resp_tx_tvalid", bus.m_tx_tvalid, 1);
    chk("resp_tx_tdata", bus.m_tx_tdata, 8'hA5);
    chk("resp_banner_tready", bus.s_banner_tready, 0);
    tick();
    bus.s_resp_tvalid   = 1'b0;
    bus.s_banner_tvalid = 1'b0;

    // lock_req together with a cmd handshake: beat delivered, then relock.
    cmd_seen.delete();
    bus.m_cmd_tready = 1'b1;
    bus.s_rx_tvalid  = 1'b1;
    bus.s_rx_tdata   = 8'h12;
    lock_req         = 1'b1;
    tick();
    lock_req         = 1'b0;
    bus.s_rx_tvalid  = 1'b0;
    chk("lockreq_cmd_count", cmd_seen.size(), 1);
    if (cmd_seen.size() == 1) chk("lockreq_cmd_data", cmd_seen[0], 8'h12);
    chk("lockreq_unlocked", unlocked, 0);

    // lock_req while locked leaves the matcher alone.
    send_str("#!ma");
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    chk("locked_lockreq_unlocked", unlocked, 0);
    chk("locked_lockreq_progress", key_progress, 4);

    // Asynchronous reset mid-key loses the partial progress.
    send_str("n");
    chk("pre_reset_progress", key_progress, 5);
    sresetn = 1'b0;
    #1;
    chk("async_reset_progress", key_progress, 0);
    model_reset();
    @(posedge clk); #1;
    sresetn = 1'b1;

    // Asynchronous reset while unlocked.
    send_str("#!manilamagic!#");
    sresetn = 1'b0;
    #1;
    chk("async_reset_unlocked", unlocked, 0);
    model_reset();
    @(posedge clk); #1;
    sresetn = 1'b1;

`ifdef UNLOCK_TIMEOUT_EN
    // Idle relock after TIMEOUT_CYCLES unlocked cycles, and restart by a beat at idle cycle 15.
    do_reset();
    send_str("#!manilamagic!#");
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_still_unlocked", unlocked, 1);
    tick();
    chk("to_relocked", unlocked, 0);
    send_str("#!manilamagic!#");
    for (int i = 0; i < TO - 2; i++) tick();
    cmd_enable       = 1'b1;
    bus.m_cmd_tready = 1'b1;
    bus.s_rx_tvalid  = 1'b1;
    bus.s_rx_tdata   = 8'h42;
    tick();
    bus.s_rx_tvalid  = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_restart_unlocked", unlocked, 1);
    tick();
    chk("to_restart_relocked", unlocked, 0);
`endif

    // Randomised traffic against the reference.
    do_reset();
    m_unlock_count = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.s_rx_tvalid     = ($urandom_range(0, 9) < 7);
      if (!m_unl && $urandom_range(0, 9) != 0) bus.s_rx_tdata = byte_t'(key_s[m_idx]);
      else                                     bus.s_rx_tdata = byte_t'($urandom);
      bus.m_cmd_tready    = 1'($urandom_range(0, 1));
      bus.s_banner_tvalid = 1'($urandom_range(0, 1));
      bus.s_banner_tdata  = byte_t'($urandom);
      bus.s_resp_tvalid   = 1'($urandom_range(0, 1));
      bus.s_resp_tdata    = byte_t'($urandom);
      bus.m_tx_tready     = 1'($urandom_range(0, 1));
      cmd_enable          = ($urandom_range(0, 7) != 0);
      lock_req            = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle_inputs();
    chk("random_unlocks_seen", (m_unlock_count > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_unlock_gate.md
# stream_unlock_gate

Parametrised gate between the UART receive FIFO and the serial Wishbone master in the bootloader. While locked it consumes every received byte and searches for a KEY_BYTES-long magic key. On a match it opens a pass-through from the receive stream to the command stream, and switches the transmit mux from the banner source to the response source. It relocks on an explicit request or, when compiled in, after an idle timeout. It replaces the fixed-key unlocker and the hand-written rx/tx muxes in the bootloader top level.

## Interface
Parameters:
- KEY_BYTES, 15: magic key length in bytes, ≥1.
- KEY, "#!manilamagic!#": key vector, KEY_BYTES*8 bits; first byte expected is KEY[KEY_BYTES*8-1 -: 8].
- TIMEOUT_CYCLES, 50_000_000: idle cycles before automatic relock (used only with UNLOCK_TIMEOUT_EN), ≥1.

Ports (reset is asynchronous, active-low):
- clk  in  1  clock.
- sresetn  in  1  asynchronous active-low reset.
- s_rx_tready / s_rx_tvalid / s_rx_tdata  in/out  1/1/8  received bytes from the FIFO (tready is the output).
- m_cmd_tready / m_cmd_tvalid / m_cmd_tdata  in/out  1/1/8  command stream to the Wishbone master (tready is the input).
- cmd_enable  in  1  pass-through permitted (e.g. protect sequence done).
- s_banner_tready / s_banner_tvalid / s_banner_tdata  out/in  1/1/8  banner source.
- s_resp_tready / s_resp_tvalid / s_resp_tdata  out/in  1/1/8  response source.
- m_tx_tready / m_tx_tvalid / m_tx_tdata  in/out  1/1/8  to the UART transmitter.
- lock_req  in  1  single-cycle relock request.
- unlocked  out  1  registered lock state.
- unlock_pulse  out  1  registered; high for one cycle on entry to UNLOCKED.
- key_progress  out  $clog2(KEY_BYTES+1)  matched-byte count.

## Operation
States: LOCKED and UNLOCKED.

LOCKED:
- s_rx_tready=1; every beat is consumed and m_cmd_tvalid=0.
- Matcher on each accepted byte b with index idx:
  - b==KEY[idx]: idx+1.
  - otherwise, b==KEY[0]: idx=1.
  - otherwise: idx=0.
- When idx reaches KEY_BYTES: go to UNLOCKED, set idx=0, pulse unlock_pulse.

UNLOCKED:
- When cmd_enable=1: m_cmd_tvalid=s_rx_tvalid, m_cmd_tdata=s_rx_tdata, s_rx_tready=m_cmd_tready, all combinational.
- When cmd_enable=0: s_rx_tready=0 and m_cmd_tvalid=0. Data stalls in the FIFO and none is dropped.
- lock_req=1: go to LOCKED next cycle, with idx=0.

TX mux:
- When unlocked=0: m_tx carries banner, and s_resp_tready=1 so the response source drains silently.
- When unlocked=1: m_tx carries resp gated by cmd_enable (m_tx_tvalid=s_resp_tvalid&&cmd_enable), and s_banner_tready=0.
- s_resp_tready when unlocked is m_tx_tready if cmd_enable, else 1.

Boundaries:
- lock_req while LOCKED: ignored; the matcher is not reset.
- lock_req in the same cycle as a cmd handshake: the beat is transferred, then the gate relocks.
- Reset mid-stream: state goes to LOCKED and idx to 0. Partial key progress is lost.

## Timing
- Reset values: unlocked=0, unlock_pulse=0, key_progress=0, m_cmd_tvalid=0, s_rx_tready=1, m_tx follows banner.
- Unlock latency: the final key byte is accepted at cycle N; unlocked=1 and unlock_pulse=1 at N+1. The first pass-through beat can be accepted at N+1.
- Relock latency: lock_req at cycle N gives unlocked=0 at N+1.
- Pass-through and TX mux add zero latency and have no internal buffering.
- key_progress is registered and updates the cycle after each accepted byte.

## Configuration
- UNLOCK_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs while UNLOCKED.
  - It clears on every s_rx handshake and on every m_tx handshake.
  - It relocks when the count equals TIMEOUT_CYCLES-1 with no handshake in that cycle.
  - It holds at 0 in LOCKED.
- UNLOCK_TIMEOUT_EN undefined: no counter is built, TIMEOUT_CYCLES is ignored, and only lock_req or reset relocks.

## Structure
- Package stream_unlock_pkg:
  - typedef enum for the states {LOCKED, UNLOCKED}.
  - byte_t typedef.
  - key_byte(KEY, i) function.
- Sub-module stream_key_matcher holds the idx register and match logic (inputs: byte, valid, clear; outputs: progress, match).

## Test plan
- Reset, then bytes "#!manilamagic!#" one per cycle → unlocked=1 and unlock_pulse=1 one cycle after the final '#'. Nothing appears on m_cmd during the key.
- "##!manilamagic!#" (repeated first byte) → unlocks. "#!manilamagiX!#" → stays locked with key_progress=0 after 'X'.
- Unlocked with cmd_enable=0: send 0x55 → s_rx_tready=0 and held. Raise cmd_enable → 0x55 appears on m_cmd with m_cmd_tready back-pressure honoured.
- Locked: banner "Manila" passes to m_tx while resp beats are discarded. After unlock, resp 0xA5 reaches m_tx and s_banner_tready=0.
- lock_req during a cmd handshake of 0x12 → 0x12 delivered, then unlocked=0 next cycle. lock_req while locked → no change.
- With UNLOCK_TIMEOUT_EN and TIMEOUT_CYCLES=16: 16 idle cycles after unlock → relock. A byte at idle cycle 15 restarts the count.
